controle_hazard: RTL
====================

Name: controle_hazard

Overview:
- Pipeline hazard scheduler for the 5-stage RISC-V core (IF/ID/EX/MEM/WB).
- Keeps a shadow record of instructions in flight in EX, MEM and WB, compares them with the source registers of the instruction in ID, and drives stall and bubble controls for the PC and pipeline registers.
- With forwarding compiled in, it also issues registered bypass selects for the EX-stage operand muxes.

Parameters:
- CNT_W, 16, width of saturating data-hazard stall counter.
- REG_W, 5, register index width.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_op  in  7  ID opcode.
- id_rs1  in  REG_W  ID source 1.
- id_rs2  in  REG_W  ID source 2.
- id_rd  in  REG_W  ID destination.
- flush  in  1  taken branch/jump resolved in EX; kill ID.
- mem_ready  in  1  data memory ready; 0 freezes whole pipeline.
- stall_if_id  out  1  hold PC and IF/ID register.
- bubble_ex  out  1  load NOP into ID/EX.
- fwd_a  out  2  EX operand-A select (00 regfile, 01 from EX/MEM, 10 from MEM/WB).
- fwd_b  out  2  same for operand B.
- stall_cnt  out  CNT_W  data-hazard stall cycles.

Behaviour:
- Decode of ID instruction (combinational):
  - uses_rs1 = (op[6] & ~op[3]) | ~op[2].
  - uses_rs2 = op in {0110011, 0100011, 1100011}.
  - writes_rd = op not in {0100011, 1100011} and rd != 0.
  - is_load = (op == 0000011).
- Shadow stages EX, MEM and WB each hold {valid, rd, writes_rd, is_load}.
- Advance occurs when mem_ready=1:
  - WB<=MEM, MEM<=EX.
  - EX<=ID record if id_valid & ~hazard & ~flush, else invalid.
- When mem_ready=0, all shadow stages and fwd_a/fwd_b hold.
- match(S) = S.valid & S.writes_rd & (S.rd matches a used ID source).
- The register file writes through, so a WB match is never a hazard.
- Hazard definition:
  - Without forwarding: hazard = id_valid & (match(EX) | match(MEM)).
  - With forwarding: hazard = id_valid & match(EX) & EX.is_load. This is the load-use case, exactly 1 bubble.
- Outputs (combinational):
  - stall_if_id = ~mem_ready | (hazard & ~flush).
  - bubble_ex = mem_ready & (flush | hazard).
- Priority: flush > hazard. Flush is sampled only when mem_ready=1, so the upstream holds flush while frozen.
- Registered forwarding selects:
  - fwd_a/fwd_b are computed at advance for the instruction entering EX:
    - 01 if EX stage currently matches that source (producer will be in MEM next).
    - else 10 if MEM stage matches.
    - else 00.
  - Nearest producer wins. Sources not used, or rs==0, give 00.
  - Bubbles entering EX give 00.
- stall_cnt increments on each cycle where hazard & ~flush & mem_ready. It saturates at all-ones and never wraps.
- Reset (asynchronous, any time, including mid-stall):
  - All shadow stages invalid.
  - fwd_a = fwd_b = 00, stall_cnt = 0.
  - Hence stall_if_id = bubble_ex = 0 unless mem_ready = 0.
- Latency:
  - Stall/bubble: same cycle as ID presentation.
  - Forward selects: valid the cycle after issue, for the whole EX residency.

Optional Feature:
- Macro: CONTROLE_HAZARD_FORWARDING_EN.
- Defined: load-use-only hazard and live fwd_a/fwd_b, as above.
- Undefined:
  - Interlock-only hazard as above (stalls up to 2 cycles).
  - fwd_a/fwd_b tied to 00; ports remain present.

Decomposition:
- Shared package (hazard_pkg):
  - Opcode constants OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE.
  - FWD_REG/FWD_EXMEM/FWD_MEMWB encodings.
  - Shadow-stage record typedef.
- One sub-module, decod_uso: opcode -> {uses_rs1, uses_rs2, writes_rd, is_load}. Instantiated once for ID.

Test Plan:
- Reset and idle: reset with mem_ready=1, id_valid=0 -> stall_if_id=0, bubble_ex=0, fwd=00, stall_cnt=0.
- Back-to-back ALU dependency:
  - Stimulus: add x5 (op 0110011, rd=5), then sub rs1=5.
  - Forwarding: no stall; next cycle fwd_a=01.
  - No forwarding: 2 stall cycles, stall_cnt=2.
- Load-use (forwarding build):
  - Stimulus: lw x7 (op 0000011), then add rs2=7.
  - Response: exactly 1 cycle stall_if_id=bubble_ex=1; on issue fwd_b=10; stall_cnt=1.
- Flush over hazard: lw x7, then dependent add with flush=1 -> bubble_ex=1, stall_if_id=0, stall_cnt unchanged.
- Memory freeze:
  - Stimulus: mem_ready=0 for 3 cycles during a load-use hazard.
  - Response: stall_if_id=1, bubble_ex=0, shadow state and fwd hold; hazard resolves after mem_ready returns.
- x0 and unused source:
  - Stimulus: producer rd=0; lui (0110111, rs1 unused) with rs1 field equal to an in-flight rd.
  - Response: no stall, fwd=00.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared opcodes, bypass encodings and shadow-stage record for the hazard unit.
// Shadow rd width is fixed by RD_W; the top's REG_W must equal it.
package hazard_pkg;

  localparam int RD_W = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            wr;
    logic            ld;
  } shadow_t;

  function automatic logic hit(
    input shadow_t         s,
    input logic            use_rs,
    input logic [RD_W-1:0] rs
  );
    return s.valid & s.wr & use_rs & (s.rd == rs);
  endfunction

endpackage

// File: rtl/controle_hazard_decod_uso.sv
// Opcode decode of register usage for the instruction sitting in ID.
// writes_op is opcode-only; the rd != 0 qualification happens in the top.
module decod_uso
  import hazard_pkg::*;
(
  input  logic [6:0] op,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       writes_op,
  output logic       is_load
);

  logic is_st;
  logic is_br;

  assign is_st     = (op == OP_STORE);
  assign is_br     = (op == OP_BRANCH);
  assign uses_rs1  = (op[6] & ~op[3]) | ~op[2];
  assign uses_rs2  = (op == OP_RTYPE) | is_st | is_br;
  assign writes_op = ~(is_st | is_br);
  assign is_load   = (op == OP_LOAD);

endmodule

// File: rtl/controle_hazard.sv
// Hazard scheduler: shadows EX/MEM/WB and drives stall, bubble and bypass.
// Define CONTROLE_HAZARD_FORWARDING_EN for load-use-only stalls and live fwd_a/fwd_b.
module controle_hazard
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [6:0]       id_op,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             flush,
  input  logic             mem_ready,
  output logic             stall_if_id,
  output logic             bubble_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  logic    u1;
  logic    u2;
  logic    wop;
  logic    ld;
  shadow_t ex;
  shadow_t mem;
  shadow_t wb;
  shadow_t id_rec;
  logic    ex_a;
  logic    ex_b;
  logic    mem_a;
  logic    mem_b;
  logic    hazard;
  logic    issue;
  logic    unused_bits;

  decod_uso u_dec (
    .op       (id_op),
    .uses_rs1 (u1),
    .uses_rs2 (u2),
    .writes_op(wop),
    .is_load  (ld)
  );

  assign id_rec = '{
    valid: 1'b1,
    rd:    id_rd,
    wr:    wop & (id_rd != '0),
    ld:    ld
  };

  assign ex_a  = hit(ex, u1, id_rs1);
  assign ex_b  = hit(ex, u2, id_rs2);
  assign mem_a = hit(mem, u1, id_rs1);
  assign mem_b = hit(mem, u2, id_rs2);

`ifdef CONTROLE_HAZARD_FORWARDING_EN
  assign hazard = id_valid & (ex_a | ex_b) & ex.ld;
`else
  assign hazard = id_valid & (ex_a | ex_b | mem_a | mem_b);
`endif

  assign issue       = id_valid & ~hazard & ~flush;
  assign stall_if_id = ~mem_ready | (hazard & ~flush);
  assign bubble_ex   = mem_ready & (flush | hazard);

  // WB is tracked for completeness; write-through regfile makes it inert
  assign unused_bits = ^{wb, mem.ld, ex.ld};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else if (mem_ready) begin
      wb  <= mem;
      mem <= ex;
      ex  <= issue ? id_rec : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (mem_ready & hazard & ~flush & ~&stall_cnt) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

`ifdef CONTROLE_HAZARD_FORWARDING_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_a <= FWD_REG;
      fwd_b <= FWD_REG;
    end else if (mem_ready) begin
      if (issue) begin
        fwd_a <= ex_a ? FWD_EXMEM : (mem_a ? FWD_MEMWB : FWD_REG);
        fwd_b <= ex_b ? FWD_EXMEM : (mem_b ? FWD_MEMWB : FWD_REG);
      end else begin
        fwd_a <= FWD_REG;
        fwd_b <= FWD_REG;
      end
    end
  end
`else
  assign fwd_a = FWD_REG;
  assign fwd_b = FWD_REG;
`endif

endmodule
